wb_imem_loader: RTL and testbench

WB_IMEM_LOADER -- requirements
Module: wb_imem_loader

---
 rtl/loader_pkg.sv | 58 +++++
 rtl/wb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_wb_imem_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the Wishbone instruction-memory loader:
//   - loader_state_t : FSM state encoding (RLANE exists only when the
//                      LOADER_READBACK_EN macro is defined)
//   - OFF_CTRL / OFF_COUNT : register offsets inside the 512-byte window
//   - CTRL_RUN_BIT / CTRL_BUSY_BIT : CTRL register bit positions
//   - lowest_lane / lane_mask / byte_lane : byte-lane helpers
// ----------------------------------------------------------------------------
package loader_pkg;

`ifdef LOADER_READBACK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WLANE = 2'd1,
        ST_RLANE = 2'd2,
        ST_ACK   = 2'd3
    } loader_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WLANE = 2'd1,
        ST_ACK   = 2'd3
    } loader_state_t;
`endif

    localparam logic [8:0] OFF_CTRL  = 9'h100;
    localparam logic [8:0] OFF_COUNT = 9'h104;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_BUSY_BIT = 1;

    // Index of the lowest set bit; callers only use it on a non-zero mask.
    function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
        logic [1:0] lane;
        if (mask[0]) begin
            lane = 2'd0;
        end else if (mask[1]) begin
            lane = 2'd1;
        end else if (mask[2]) begin
            lane = 2'd2;
        end else begin
            lane = 2'd3;
        end
        return lane;
    endfunction

    // One-hot mask for a single byte lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Byte lane extraction from a 32-bit word, little-endian.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/wb_imem_loader.sv
// ----------------------------------------------------------------------------
// wb_imem_loader
// Wishbone classic slave that lets a host load a 256-byte instruction memory
// one byte per cycle while the CPU is held in reset.
//
// Window (adr[31:9] == BASE_ADDR[31:9]):
//   0x000-0x0FF IMEM   writes split into one byte write per selected lane
//   0x100       CTRL   bit0 run (R/W), bit1 busy (RO); cpu_reset_o = ~run
//   0x104       COUNT  bytes written since run was last cleared, saturating
//   other       acked with data 0, no side effect
//
// Optional feature: define LOADER_READBACK_EN to make IMEM reads fetch all
// four bytes through imem_r_data_i (RLANE state). Without it, IMEM reads ack
// immediately with 0 and imem_r_data_i is ignored.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, async active-high reset
//   wbs_stb_i/cyc_i/we_i/sel_i    Wishbone request qualifiers
//   wbs_adr_i, wbs_dat_i          byte address, write data
//   wbs_ack_o, wbs_dat_o          single-cycle ack, read data
//   imem_addr_o, imem_w_data_o,
//   imem_w_en_o, imem_r_data_i    instruction-memory byte port
//   cpu_reset_o                   hold-reset to the CPU while loading
// ----------------------------------------------------------------------------
module wb_imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          IMEM_DEPTH = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  imem_addr_o,
    output logic [7:0]  imem_w_data_o,
    output logic        imem_w_en_o,
    input  logic [7:0]  imem_r_data_i,
    output logic        cpu_reset_o
);

    loader_state_t state_r, state_nxt_s;
    logic [3:0]    pend_r, pend_nxt_s;       // lanes still to be written
    logic [5:0]    word_r, word_nxt_s;       // word index of current access
    logic [31:0]   wdata_r, wdata_nxt_s;
    logic          run_r, run_nxt_s;
    logic          cpu_reset_r;
    logic [7:0]    count_r, count_nxt_s;
    logic          ack_r, ack_nxt_s;
    logic [31:0]   dat_r, dat_nxt_s;
    logic [7:0]    addr_r, addr_nxt_s;
    logic [7:0]    wbyte_r, wbyte_nxt_s;
    logic          wen_r, wen_nxt_s;

    logic          hit_s;
    logic          is_imem_s;
    logic          is_ctrl_s;
    logic          is_count_s;
    logic          busy_s;
    logic [1:0]    req_lane_s;
    logic [1:0]    pend_lane_s;

`ifdef LOADER_READBACK_EN
    logic [1:0]    lane_r, lane_nxt_s;       // read lane sequencer
    logic [23:0]   rbuf_r, rbuf_nxt_s;       // lanes 0..2 of the read word
    logic          rd_live_r, rd_live_nxt_s; // current ack carries IMEM read data
`endif

    // Tie-off of inputs and parameters that carry no information here.
    logic unused_s;
`ifdef LOADER_READBACK_EN
    assign unused_s = ^{wbs_adr_i[1:0], wbs_stb_i & 1'b0, (IMEM_DEPTH == 256)};
`else
    assign unused_s = ^{wbs_adr_i[1:0], imem_r_data_i, (IMEM_DEPTH == 256)};
`endif

    assign hit_s       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:9] == BASE_ADDR[31:9]);
    assign is_imem_s   = ~wbs_adr_i[8];
    assign is_ctrl_s   = (wbs_adr_i[8:2] == OFF_CTRL[8:2]);
    assign is_count_s  = (wbs_adr_i[8:2] == OFF_COUNT[8:2]);
    assign busy_s      = (state_r != ST_IDLE);
    assign req_lane_s  = lowest_lane(wbs_sel_i);
    assign pend_lane_s = lowest_lane(pend_r);

    assign wbs_ack_o     = ack_r;
    assign imem_addr_o   = addr_r;
    assign imem_w_data_o = wbyte_r;
    assign imem_w_en_o   = wen_r;
    assign cpu_reset_o   = cpu_reset_r;

`ifdef LOADER_READBACK_EN
    // Lane 3 arrives from the memory in the ack cycle itself, so it is
    // passed straight through instead of costing another cycle of latency.
    assign wbs_dat_o = rd_live_r ? {imem_r_data_i, rbuf_r} : dat_r;
`else
    assign wbs_dat_o = dat_r;
`endif

    // Next-state and next-output logic of the loader FSM.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        word_nxt_s  = word_r;
        wdata_nxt_s = wdata_r;
        run_nxt_s   = run_r;
        addr_nxt_s  = addr_r;
        wbyte_nxt_s = wbyte_r;
        ack_nxt_s   = 1'b0;
        dat_nxt_s   = 32'h0000_0000;
        wen_nxt_s   = 1'b0;
`ifdef LOADER_READBACK_EN
        lane_nxt_s    = lane_r;
        rbuf_nxt_s    = rbuf_r;
        rd_live_nxt_s = 1'b0;
`endif
        // Every byte strobed out is counted as it is written.
        if (wen_r && (count_r != 8'hFF)) begin
            count_nxt_s = count_r + 8'd1;
        end else begin
            count_nxt_s = count_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    if (is_imem_s) begin
                        if (wbs_we_i) begin
                            // Loading is locked out while the CPU runs.
                            if (run_r || (wbs_sel_i == 4'b0000)) begin
                                ack_nxt_s   = 1'b1;
                                state_nxt_s = ST_ACK;
                            end else begin
                                word_nxt_s  = wbs_adr_i[7:2];
                                wdata_nxt_s = wbs_dat_i;
                                addr_nxt_s  = {wbs_adr_i[7:2], req_lane_s};
                                wbyte_nxt_s = byte_lane(wbs_dat_i, req_lane_s);
                                wen_nxt_s   = 1'b1;
                                pend_nxt_s  = wbs_sel_i & ~lane_mask(req_lane_s);
                                state_nxt_s = ST_WLANE;
                            end
                        end else begin
`ifdef LOADER_READBACK_EN
                            word_nxt_s  = wbs_adr_i[7:2];
                            addr_nxt_s  = {wbs_adr_i[7:2], 2'd0};
                            lane_nxt_s  = 2'd0;
                            state_nxt_s = ST_RLANE;
`else
                            ack_nxt_s   = 1'b1;
                            state_nxt_s = ST_ACK;
`endif
                        end
                    end else if (is_ctrl_s) begin
                        if (wbs_we_i) begin
                            run_nxt_s   = wbs_dat_i[CTRL_RUN_BIT];
                            count_nxt_s = (run_r && !wbs_dat_i[CTRL_RUN_BIT]) ? 8'h00 : count_r;
                        end else begin
                            dat_nxt_s                = 32'h0000_0000;
                            dat_nxt_s[CTRL_RUN_BIT]  = run_r;
                            dat_nxt_s[CTRL_BUSY_BIT] = busy_s;
                        end
                        ack_nxt_s   = 1'b1;
                        state_nxt_s = ST_ACK;
                    end else if (is_count_s) begin
                        dat_nxt_s   = wbs_we_i ? 32'h0000_0000 : {24'h00_0000, count_r};
                        ack_nxt_s   = 1'b1;
                        state_nxt_s = ST_ACK;
                    end else begin
                        ack_nxt_s   = 1'b1;
                        state_nxt_s = ST_ACK;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_WLANE: begin
                // A master that abandons the cycle loses the remaining lanes.
                if (!wbs_cyc_i) begin
                    pend_nxt_s  = 4'b0000;
                    state_nxt_s = ST_IDLE;
                end else if (pend_r != 4'b0000) begin
                    addr_nxt_s  = {word_r, pend_lane_s};
                    wbyte_nxt_s = byte_lane(wdata_r, pend_lane_s);
                    wen_nxt_s   = 1'b1;
                    pend_nxt_s  = pend_r & ~lane_mask(pend_lane_s);
                end else begin
                    ack_nxt_s   = 1'b1;
                    state_nxt_s = ST_ACK;
                end
            end

`ifdef LOADER_READBACK_EN
            ST_RLANE: begin
                // lane_r names the address on the bus; the byte on
                // imem_r_data_i belongs to the lane before it.
                if (!wbs_cyc_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    case (lane_r)
                        2'd1:    rbuf_nxt_s[7:0]   = imem_r_data_i;
                        2'd2:    rbuf_nxt_s[15:8]  = imem_r_data_i;
                        2'd3:    rbuf_nxt_s[23:16] = imem_r_data_i;
                        default: rbuf_nxt_s        = rbuf_r;
                    endcase
                    if (lane_r == 2'd3) begin
                        ack_nxt_s     = 1'b1;
                        rd_live_nxt_s = 1'b1;
                        state_nxt_s   = ST_ACK;
                    end else begin
                        lane_nxt_s = lane_r + 2'd1;
                        addr_nxt_s = {word_r, lane_r + 2'd1};
                    end
                end
            end
`endif

            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            pend_r      <= 4'b0000;
            word_r      <= 6'd0;
            wdata_r     <= 32'h0000_0000;
            run_r       <= 1'b0;
            cpu_reset_r <= 1'b1;
            count_r     <= 8'h00;
            ack_r       <= 1'b0;
            dat_r       <= 32'h0000_0000;
            addr_r      <= 8'h00;
            wbyte_r     <= 8'h00;
            wen_r       <= 1'b0;
`ifdef LOADER_READBACK_EN
            lane_r      <= 2'd0;
            rbuf_r      <= 24'h00_0000;
            rd_live_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            pend_r      <= pend_nxt_s;
            word_r      <= word_nxt_s;
            wdata_r     <= wdata_nxt_s;
            run_r       <= run_nxt_s;
            cpu_reset_r <= ~run_nxt_s;
            count_r     <= count_nxt_s;
            ack_r       <= ack_nxt_s;
            dat_r       <= dat_nxt_s;
            addr_r      <= addr_nxt_s;
            wbyte_r     <= wbyte_nxt_s;
            wen_r       <= wen_nxt_s;
`ifdef LOADER_READBACK_EN
            lane_r      <= lane_nxt_s;
            rbuf_r      <= rbuf_nxt_s;
            rd_live_r   <= rd_live_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_wb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_wb_imem_loader
// Directed and random Wishbone traffic into wb_imem_loader. The stimulus
// process updates a byte-array reference of the instruction memory plus
// run/count state, and pushes the expected ack latency, write-pulse count,
// cpu_reset level and read data into a queue; an independent monitor pops
// and compares whenever the DUT acks. A behavioural byte RAM with one-cycle
// read latency sits on the imem port and is compared to the reference at
// the end.
// ----------------------------------------------------------------------------
module tb_wb_imem_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  m_addr, m_wdata, m_rdata;
    logic        m_wen;
    logic        cpu_rst;
    logic        mem_clr = 1'b1;

    wb_imem_loader #(.BASE_ADDR(BASE), .IMEM_DEPTH(256)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .imem_addr_o   (m_addr),
        .imem_w_data_o (m_wdata),
        .imem_w_en_o   (m_wen),
        .imem_r_data_i (m_rdata),
        .cpu_reset_o   (cpu_rst)
    );

    always #5 clk = ~clk;

    // Behavioural instruction memory on the DUT's byte port.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (m_wen) begin
            mem[m_addr] <= m_wdata;
        end
        m_rdata <= mem[m_addr];
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model state.
    logic [7:0] exp_mem [256];
    logic       exp_run = 1'b0;
    int         exp_count = 0;

    typedef struct {
        int          id;
        int          issue;
        int          lat;
        int          wen0;
        int          k;
        logic        is_rd;
        logic [31:0] dat;
        logic [31:0] mask;
        logic        cpurst;
    } exp_t;
    exp_t sbq[$];

    int total = 0, bad = 0;
    int wen_total = 0, ack_total = 0;
    int txn_id = 0;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s txn=%0d actual=%h required=%h", nm, id, act, req);
        end
    endtask

    // Monitor: counts write pulses and scores every ack against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_wen === 1'b1) wen_total++;
            if (ack === 1'b1) begin
                ack_total++;
                if (sbq.size() == 0) begin
                    check("unexpected_ack", -1, 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("ack_latency", e.id, cyc_cnt - e.issue, e.lat);
                    check("write_pulses", e.id, wen_total - e.wen0, e.k);
                    check("cpu_reset", e.id, {31'd0, cpu_rst}, {31'd0, e.cpurst});
                    if (e.is_rd) check("read_data", e.id, rdat & e.mask, e.dat);
                end
            end
        end
    end

    // Issue one transaction with precomputed expectations and wait for ack.
    task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [3:0] t_sel,
                       input logic [31:0] t_dat, input int lat, input int k,
                       input logic [31:0] edat, input logic [31:0] emask);
        exp_t e;
        bit   got;
        @(negedge clk);
        e.id = txn_id; e.issue = cyc_cnt; e.lat = lat; e.wen0 = wen_total; e.k = k;
        e.is_rd = !t_we; e.dat = edat; e.mask = emask; e.cpurst = !exp_run;
        txn_id++;
        sbq.push_back(e);
        stb = 1'b1; cyc = 1'b1; we = t_we; sel = t_sel; adr = t_adr; wdat = t_dat;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack === 1'b1) got = 1'b1;
        end
        check("ack_seen", e.id, {31'd0, got}, 32'd1);
        if (!got && sbq.size() > 0) void'(sbq.pop_front());
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic imem_write(input int w, input logic [3:0] s, input logic [31:0] d);
        int k = 0;
        if (!exp_run) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) begin
                    exp_mem[w*4 + i] = d[8*i +: 8];
                    k++;
                end
            end
        end
        exp_count = (exp_count + k > 255) ? 255 : exp_count + k;
        txn(1'b1, BASE | (w * 4), s, d, k + 1, k, 32'h0, 32'h0);
    endtask

    task automatic imem_read(input int w);
`ifdef LOADER_READBACK_EN
        txn(1'b0, BASE | (w * 4), 4'h0, 32'h0, 5, 0,
            {exp_mem[w*4+3], exp_mem[w*4+2], exp_mem[w*4+1], exp_mem[w*4]}, 32'hFFFF_FFFF);
`else
        txn(1'b0, BASE | (w * 4), 4'hF, 32'h0, 1, 0, 32'h0, 32'hFFFF_FFFF);
`endif
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        if (exp_run && !d[0]) exp_count = 0;
        exp_run = d[0];
        txn(1'b1, BASE | 32'h100, 4'hF, d, 1, 0, 32'h0, 32'h0);
    endtask

    task automatic ctrl_read();
        // busy (bit1) depends on sampling instant and is not scored.
        txn(1'b0, BASE | 32'h100, 4'hF, 32'h0, 1, 0, {31'd0, exp_run}, 32'hFFFF_FFFD);
    endtask

    task automatic count_read();
        txn(1'b0, BASE | 32'h104, 4'hF, 32'h0, 1, 0, exp_count, 32'hFFFF_FFFF);
    endtask

    task automatic other_access(input int off, input logic t_we);
        txn(t_we, BASE | off, 4'hF, 32'hDEAD_BEEF, 1, 0, 32'h0, 32'hFFFF_FFFF);
    endtask

    // Address outside the window: nothing may answer.
    task automatic outside_access(input logic [31:0] a);
        int a0;
        @(negedge clk);
        a0 = ack_total;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = a; wdat = 32'h1234_5678;
        repeat (4) @(negedge clk);
        check("outside_no_ack", txn_id, ack_total, a0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic check_reset_outputs(input int id);
        check("rst_ack", id, {31'd0, ack}, 32'd0);
        check("rst_dat", id, rdat, 32'd0);
        check("rst_wen", id, {31'd0, m_wen}, 32'd0);
        check("rst_addr", id, {24'd0, m_addr}, 32'd0);
        check("rst_wdata", id, {24'd0, m_wdata}, 32'd0);
        check("rst_cpu_reset", id, {31'd0, cpu_rst}, 32'd1);
    endtask

    initial begin
        int          op, w, tmp;
        logic [31:0] r;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        mem_clr = 1'b0;
        rst = 1'b0;

        // Basic load sequence.
        ctrl_write(32'h0);
        imem_write(0, 4'b1111, 32'hDDCC_BBAA);
        count_read();
        imem_write(5, 4'b1010, 32'h1122_3344);
        imem_write(8, 4'b1111, 32'h0403_0201);
        imem_read(8);
        imem_write(9, 4'b0000, 32'hFFFF_FFFF);
        count_read();
        other_access(32'h180, 1'b0);
        other_access(32'h1FC, 1'b1);
        outside_access(BASE + 32'h200);
        outside_access(32'h4000_0000);

        // Run locks out loading; clearing run clears COUNT.
        ctrl_write(32'h1);
        imem_write(2, 4'b1111, 32'h5555_5555);
        ctrl_read();
        count_read();
        ctrl_write(32'h0);
        count_read();
        ctrl_read();

        // Cycle dropped after the second lane of a full-word write.
        @(negedge clk);
        tmp = wen_total;
        w = ack_total;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE | 32'h40; wdat = 32'hA4A3_A2A1;
        exp_mem[8'h40] = 8'hA1;
        exp_mem[8'h41] = 8'hA2;
        exp_count = exp_count + 2;
        @(negedge clk);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_pulses", txn_id, wen_total - tmp, 32'd2);
        check("drop_no_ack", txn_id, ack_total, w);
        count_read();

        // Reset in the middle of a write: lane 0 lands, lane 1 is cut off.
        @(negedge clk);
        w = ack_total;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE | 32'h50; wdat = 32'hB4B3_B2B1;
        exp_mem[8'h50] = 8'hB1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs(txn_id);
        exp_run = 1'b0;
        exp_count = 0;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tmp = wen_total;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_pulses", txn_id, wen_total - tmp, 32'd0);
        check("reset_no_ack", txn_id, ack_total, w);
        count_read();
        ctrl_read();

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            w  = $urandom_range(0, 63);
            r  = $urandom;
            if (op <= 4) begin
                tmp = $urandom_range(0, 15);
                imem_write(w, tmp[3:0], r);
            end else if (op == 5) begin
                imem_read(w);
            end else if (op == 6) begin
                tmp = ($urandom_range(0, 7) == 0) ? 1 : 0;
                ctrl_write({r[31:1], tmp[0]});
            end else if (op == 7) begin
                count_read();
            end else if (op == 8) begin
                ctrl_read();
            end else begin
                tmp = $urandom_range(0, 3);
                if (tmp == 0) outside_access(BASE + 32'h200 + (w * 4));
                else other_access(32'h108 + 4 * $urandom_range(0, 61), r[0]);
            end
        end
        count_read();

        // Memory contents against the reference.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) check("mem_byte", i, {24'd0, mem[i]}, {24'd0, exp_mem[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit actual=expired required=finished");
        $fatal(1, "watchdog");
    end

endmodule
